data_mem_arbiter: RTL and testbench



---
 rtl/data_mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port req/ack arbiter and access sequencer for a
// single-port data memory. Each transaction runs IDLE -> ACCESS -> RESP.
// Port 0 (core load/store) and port 1 (init/DMA loader) share the memory.
// Optional feature macro: ARB_ROUND_ROBIN_EN. When it is defined, contention
// goes to the port that did not win last time. When it is undefined, port 0
// always wins contention.
`timescale 1ns/1ps

module data_mem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          busy,
    output logic [AW-1:0] ram_address,
    output logic          ram_write_mem,
    output logic [DW-1:0] ram_data_in,
    input  logic [DW-1:0] ram_data_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    state_e        state_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          win_q;
    logic          last_grant_q;
    logic          last_grant_d;
    logic          ack0_q;
    logic          ack1_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;
    logic          busy_q;
    logic          wr_q;

    logic          any_req_s;
    logic          win_d;
    logic          we_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d;

    assign any_req_s = req0 | req1;

    // Pick the winning port from the current requests (a single request always wins).
    always_comb begin
        win_d = 1'b0;
        if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
            win_d = ~last_grant_q;
`else
            win_d = 1'b0;
`endif
        end else if (req1) begin
            win_d = 1'b1;
        end else begin
            win_d = 1'b0;
        end
    end

    // Steer the winner's command fields toward the latch registers.
    always_comb begin
        we_d    = we0;
        addr_d  = addr0;
        wdata_d = wdata0;
        if (win_d) begin
            we_d    = we1;
            addr_d  = addr1;
            wdata_d = wdata1;
        end else begin
            we_d    = we0;
            addr_d  = addr0;
            wdata_d = wdata0;
        end
    end

    // Record the winner as last_grant once its response cycle is reached.
    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == S_RESP) begin
            last_grant_d = win_q;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Transaction sequencer: the state register plus every registered output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            addr_q       <= {AW{1'b0}};
            wdata_q      <= {DW{1'b0}};
            win_q        <= 1'b0;
            last_grant_q <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= {DW{1'b0}};
            rdata1_q     <= {DW{1'b0}};
            busy_q       <= 1'b0;
            wr_q         <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            case (state_q)
                S_IDLE: begin
                    ack0_q <= 1'b0;
                    ack1_q <= 1'b0;
                    if (any_req_s) begin
                        we_q    <= we_d;
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                        win_q   <= win_d;
                        wr_q    <= we_d;
                        busy_q  <= 1'b1;
                        state_q <= S_ACCESS;
                    end else begin
                        wr_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_ACCESS: begin
                    // The memory read is combinational, so capture it here.
                    if (!we_q) begin
                        if (win_q) begin
                            rdata1_q <= ram_data_out;
                        end else begin
                            rdata0_q <= ram_data_out;
                        end
                    end else begin
                        rdata0_q <= rdata0_q;
                    end
                    wr_q    <= 1'b0;
                    ack0_q  <= ~win_q;
                    ack1_q  <= win_q;
                    busy_q  <= 1'b1;
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    wr_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    wr_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack0          = ack0_q;
    assign ack1          = ack1_q;
    assign rdata0        = rdata0_q;
    assign rdata1        = rdata1_q;
    assign busy          = busy_q;
    assign ram_address   = addr_q;
    assign ram_write_mem = wr_q;
    assign ram_data_in   = wdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: a table of single transactions,
// hand sequences for contention and reset corner cases, then randomized
// traffic against a transaction-level reference model.
`timescale 1ns/1ps

module tb_data_mem_arbiter;

    logic       clk;
    logic       reset;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       ack0, ack1, busy, ram_write_mem;
    logic [7:0] rdata0, rdata1, ram_address, ram_data_in, ram_data_out;

    logic [7:0] mem [256] = '{default: 8'h00};
    logic [7:0] ref_mem [256];

    int n_chk = 0;
    int n_err = 0;

    data_mem_arbiter #(.AW(8), .DW(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .busy(busy), .ram_address(ram_address), .ram_write_mem(ram_write_mem),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    // Single-port memory: combinational read, no reset.
    assign ram_data_out = mem[ram_address];
    always @(posedge clk) begin
        if (ram_write_mem) mem[ram_address] <= ram_data_in;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         p;
        bit         w;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] erd;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit p, input bit r, input bit w, input logic [7:0] a, input logic [7:0] d);
        if (p) begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One transaction issued in an IDLE cycle N: ACCESS at N+1, ack at N+2.
    task automatic do_txn(input bit p, input bit w, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] erd, input string nm);
        set_req(p, 1'b1, w, a, d);
        tick();
        chk({nm, "/wr"}, ram_write_mem, w);
        chk({nm, "/addr"}, ram_address, a);
        if (w) chk({nm, "/wdata"}, ram_data_in, d);
        chk({nm, "/busy1"}, busy, 1'b1);
        chk({nm, "/noack"}, ack0 | ack1, 1'b0);
        tick();
        chk({nm, "/ack0"}, ack0, !p);
        chk({nm, "/ack1"}, ack1, p);
        chk({nm, "/rdata"}, p ? rdata1 : rdata0, erd);
        chk({nm, "/wr_off"}, ram_write_mem, 1'b0);
        set_req(p, 1'b0, w, a, d);
        tick();
        chk({nm, "/idle"}, {busy, ack0, ack1}, 3'b000);
    endtask

    // Random-phase model state.
    bit         act [2];
    bit         grd [2];
    bit         r_we [2];
    logic [7:0] r_addr [2];
    logic [7:0] r_wd [2];
    logic [7:0] exp_rd [2];
    bit         g_valid, g_port, g_we, last_g, w_sel;
    logic [7:0] g_addr, g_wdata, g_rd;
    int         g_t, rel;
    bit         e_ack0, e_ack1, e_wr, e_busy;

    initial begin
        vec_t tbl [9];
        bit first;
        bit win;

        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
        tick();
        tick();
        reset = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_idle", {ack0, ack1, busy, ram_write_mem}, 4'b0000);
            chk("rst_rdata", {rdata0, rdata1}, 16'h0000);
        end

        // Directed single transactions.
        tbl[0] = '{1'b0, 1'b1, 8'h10, 8'hA5, 8'h00};
        tbl[1] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5};
        tbl[2] = '{1'b1, 1'b1, 8'h20, 8'h11, 8'h00};
        tbl[3] = '{1'b1, 1'b1, 8'h21, 8'h22, 8'h00};
        tbl[4] = '{1'b1, 1'b0, 8'h21, 8'h00, 8'h22};
        tbl[5] = '{1'b0, 1'b1, 8'h10, 8'h5A, 8'hA5};
        tbl[6] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'h5A};
        tbl[7] = '{1'b0, 1'b0, 8'h20, 8'h00, 8'h11};
        tbl[8] = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h11};
        for (int i = 0; i < 9; i++) begin
            do_txn(tbl[i].p, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].erd, $sformatf("vec%0d", i));
        end

        // Contention on 0xFF: port 0 read vs port 1 write of 0x3C; port 0 won last.
`ifdef ARB_ROUND_ROBIN_EN
        first = 1'b1;
`else
        first = 1'b0;
`endif
        set_req(1'b0, 1'b1, 1'b0, 8'hFF, 8'h00);
        set_req(1'b1, 1'b1, 1'b1, 8'hFF, 8'h3C);
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 3) set_req(first, 1'b0, 1'b0, 8'h00, 8'h00);
            chk("ff_ack0", ack0, (c == 2 && !first) || (c == 5 && first));
            chk("ff_ack1", ack1, (c == 2 && first) || (c == 5 && !first));
            if ((c == 2 && !first) || (c == 5 && first))
                chk("ff_rdata0", rdata0, first ? 8'h3C : 8'h00);
            if (c == 5) set_req(!first, 1'b0, 1'b0, 8'h00, 8'h00);
        end
        do_txn(1'b0, 1'b0, 8'hFF, 8'h00, 8'h3C, "ff_reread");

        // Continuous contention on reads of 0x20/0x21 from reset.
        apply_reset();
        set_req(1'b0, 1'b1, 1'b0, 8'h20, 8'h00);
        set_req(1'b1, 1'b1, 1'b0, 8'h21, 8'h00);
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c == 12) set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
`ifdef ARB_ROUND_ROBIN_EN
            win = ((c - 2) / 3) % 2 == 1;
`else
            win = 1'b0;
`endif
            chk("cont_ack0", ack0, (c % 3 == 2) && (c <= 11) && !win);
            chk("cont_ack1", ack1, ((c % 3 == 2) && (c <= 11) && win) || (c == 14));
            if (ack0) chk("cont_rdata0", rdata0, 8'h11);
            if (ack1) chk("cont_rdata1", rdata1, 8'h22);
            if (c == 14) set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        end

        // Reset during ACCESS of a port 0 write: the write still lands.
        set_req(1'b0, 1'b1, 1'b1, 8'h05, 8'h77);
        tick();
        chk("rstw_wr", ram_write_mem, 1'b1);
        reset = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        reset = 1'b0;
        chk("rstw_state", {ack0, ack1, busy}, 3'b000);
        tick();
        chk("rstw_noack", {ack0, ack1, busy}, 3'b000);
        do_txn(1'b0, 1'b0, 8'h05, 8'h00, 8'h77, "rstw_read");

        // Reset during ACCESS of a port 1 read: no ack, rdata1 cleared.
        do_txn(1'b1, 1'b0, 8'h21, 8'h00, 8'h22, "rstr_pre");
        set_req(1'b1, 1'b1, 1'b0, 8'h20, 8'h00);
        tick();
        reset = 1'b1;
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        reset = 1'b0;
        chk("rstr_noack", {ack0, ack1, busy}, 3'b000);
        chk("rstr_rdata1", rdata1, 8'h00);
        do_txn(1'b1, 1'b0, 8'h20, 8'h00, 8'h11, "rstr_reissue");

        // Randomized traffic against a transaction-level model.
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        ref_mem[8'h10] = 8'h5A;
        ref_mem[8'h20] = 8'h11;
        ref_mem[8'h21] = 8'h22;
        ref_mem[8'hFF] = 8'h3C;
        ref_mem[8'h05] = 8'h77;
        apply_reset();
        for (int p = 0; p < 2; p++) begin
            act[p] = 1'b0; grd[p] = 1'b0; exp_rd[p] = 8'h00;
            r_we[p] = 1'b0; r_addr[p] = 8'h00; r_wd[p] = 8'h00;
        end
        g_valid = 1'b0; g_t = -10; last_g = 1'b1;
        g_port = 1'b0; g_we = 1'b0; g_addr = 8'h00; g_wdata = 8'h00; g_rd = 8'h00;

        for (int t = 0; t < 3000; t++) begin
            tick();
            e_ack0 = g_valid && (t == g_t + 2) && !g_port;
            e_ack1 = g_valid && (t == g_t + 2) && g_port;
            e_wr   = g_valid && (t == g_t + 1) && g_we;
            e_busy = g_valid && ((t == g_t + 1) || (t == g_t + 2));
            rel = -1;
            if (g_valid && (t == g_t + 2)) begin
                if (!g_we) exp_rd[g_port] = g_rd;
                rel = int'(g_port);
            end
            chk("rnd_ack0", ack0, e_ack0);
            chk("rnd_ack1", ack1, e_ack1);
            chk("rnd_wr", ram_write_mem, e_wr);
            chk("rnd_busy", busy, e_busy);
            chk("rnd_rdata0", rdata0, exp_rd[0]);
            chk("rnd_rdata1", rdata1, exp_rd[1]);
            if (g_valid && (t == g_t + 1)) chk("rnd_addr", ram_address, g_addr);
            if (e_wr) chk("rnd_wdata", ram_data_in, g_wdata);

            // Requesters: hold until ack, may alter fields before grant.
            for (int p = 0; p < 2; p++) begin
                if (act[p]) begin
                    if (!grd[p] && $urandom_range(0, 3) == 0) begin
                        r_we[p] = 1'($urandom_range(0, 1));
                        r_addr[p] = 8'($urandom_range(0, 255));
                        r_wd[p] = 8'($urandom_range(0, 255));
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    act[p] = 1'b1;
                    grd[p] = 1'b0;
                    r_we[p] = 1'($urandom_range(0, 1));
                    r_addr[p] = 8'($urandom_range(0, 255));
                    r_wd[p] = 8'($urandom_range(0, 255));
                end
                set_req(p[0], act[p], r_we[p], r_addr[p], r_wd[p]);
            end

            // Arbiter free three cycles after its previous grant.
            if ((!g_valid || t >= g_t + 3) && (act[0] || act[1])) begin
`ifdef ARB_ROUND_ROBIN_EN
                w_sel = (act[0] && act[1]) ? !last_g : act[1];
`else
                w_sel = !act[0];
`endif
                g_valid = 1'b1;
                g_t = t;
                g_port = w_sel;
                g_we = r_we[w_sel];
                g_addr = r_addr[w_sel];
                g_wdata = r_wd[w_sel];
                grd[w_sel] = 1'b1;
                last_g = w_sel;
                if (g_we) ref_mem[g_addr] = g_wdata;
                else g_rd = ref_mem[g_addr];
            end
            if (rel >= 0) act[rel] = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
